// File: rtl/axi_wr_slave_engine_pkg.sv
// Shared types and default widths for the AXI write-channel slave engine.
package axi_wr_slave_engine_pkg;

    localparam int PID_WIDTH     = 4;
    localparam int PADDR_WIDTH   = 32;
    localparam int PLENGTH_WIDTH = 8;
    localparam int PSIZE_WIDTH   = 3;
    localparam int PDATA_WIDTH   = 4;

    localparam logic [1:0] BURST_INCR = 2'b01;

    typedef enum logic [1:0] {
        RESP_OKAY   = 2'b00,
        RESP_SLVERR = 2'b10
    } resp_t;

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        DATA = 2'b01,
        RESP = 2'b10
    } wr_state_t;

    typedef struct packed {
        logic [PID_WIDTH-1:0]     id;
        logic [PADDR_WIDTH-1:0]   addr;
        logic [PLENGTH_WIDTH-1:0] len;
        logic [PSIZE_WIDTH-1:0]   size;
        logic [1:0]               burst;
    } aw_entry_t;

    typedef struct packed {
        logic [PID_WIDTH-1:0] id;
        resp_t                resp;
    } b_entry_t;

endpackage

// File: rtl/axi_wr_slave_engine_sync_fifo.sv
// Synchronous show-ahead FIFO; push while full is accepted when a pop happens the same cycle.
module axi_wr_slave_engine_sync_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic [WIDTH-1:0] wdata,
    input  logic             pop,
    output logic [WIDTH-1:0] rdata,
    output logic             full,
    output logic             empty
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam logic [PTR_W:0] PTR_ONE = {{PTR_W{1'b0}}, 1'b1};

    logic [WIDTH-1:0] mem_r [DEPTH];
    logic [PTR_W:0]   wr_ptr_r;
    logic [PTR_W:0]   rd_ptr_r;
    logic             do_push_s;
    logic             do_pop_s;

    // Extra pointer MSB distinguishes full from empty when the indices match.
    assign empty     = (wr_ptr_r == rd_ptr_r);
    assign full      = (wr_ptr_r[PTR_W] != rd_ptr_r[PTR_W]) &&
                       (wr_ptr_r[PTR_W-1:0] == rd_ptr_r[PTR_W-1:0]);
    assign do_pop_s  = pop && !empty;
    assign do_push_s = push && (!full || do_pop_s);
    assign rdata     = mem_r[rd_ptr_r[PTR_W-1:0]];

    // Read/write pointer update.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_r <= '0;
            rd_ptr_r <= '0;
        end else begin
            if (do_push_s) begin
                wr_ptr_r <= wr_ptr_r + PTR_ONE;
            end
            if (do_pop_s) begin
                rd_ptr_r <= rd_ptr_r + PTR_ONE;
            end
        end
    end

    // Entry storage.
    always_ff @(posedge clk) begin
        if (do_push_s) begin
            mem_r[wr_ptr_r[PTR_W-1:0]] <= wdata;
        end
    end

endmodule

// File: rtl/axi_wr_slave_engine.sv
// AXI write slave: AW queue -> per-burst beat streaming to a memory sink -> in-order B queue.
// Optional burst protocol checking is compiled in with AXI_WR_ERR_CHK_EN.
module axi_wr_slave_engine
    import axi_wr_slave_engine_pkg::*;
#(
    parameter int ID_W        = PID_WIDTH,
    parameter int ADDR_W      = PADDR_WIDTH,
    parameter int LEN_W       = PLENGTH_WIDTH,
    parameter int SIZE_W      = PSIZE_WIDTH,
    parameter int DATA_BYTES  = PDATA_WIDTH,
    parameter int OUTSTANDING = 4,
    parameter int B_DEPTH     = 2
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [ID_W-1:0]         awid,
    input  logic [ADDR_W-1:0]       awaddr,
    input  logic [LEN_W-1:0]        awlen,
    input  logic [SIZE_W-1:0]       awsize,
    input  logic [1:0]              awburst,
    input  logic                    awvalid,
    output logic                    awready,
    input  logic [ID_W-1:0]         wid,
    input  logic [DATA_BYTES*8-1:0] wdata,
    input  logic [DATA_BYTES-1:0]   wstrb,
    input  logic                    wlast,
    input  logic                    wvalid,
    output logic                    wready,
    output logic [ID_W-1:0]         bid,
    output logic [1:0]              bresp,
    output logic                    bvalid,
    input  logic                    bready,
    output logic                    mem_valid,
    output logic [ADDR_W-1:0]       mem_addr,
    output logic [DATA_BYTES*8-1:0] mem_wdata,
    output logic [DATA_BYTES-1:0]   mem_wstrb,
    input  logic                    mem_ready
);

    localparam logic [LEN_W:0] BEAT_ONE = {{LEN_W{1'b0}}, 1'b1};
    localparam logic [LEN_W:0] BEAT_MAX = {(LEN_W+1){1'b1}};

    wr_state_t         state_r;
    wr_state_t         state_nxt_s;
    logic [ID_W-1:0]   id_r;
    logic [ADDR_W-1:0] addr_r;
    logic [LEN_W-1:0]  len_r;
    logic [SIZE_W-1:0] size_r;
    logic [1:0]        burst_r;
    logic [LEN_W:0]    beat_cnt_r;

    aw_entry_t aw_in_s;
    aw_entry_t aw_head_s;
    logic      aw_push_s;
    logic      aw_pop_s;
    logic      aw_full_s;
    logic      aw_empty_s;

    b_entry_t  b_in_s;
    b_entry_t  b_head_s;
    logic      b_push_s;
    logic      b_pop_s;
    logic      b_full_s;
    logic      b_empty_s;

    logic      in_data_s;
    logic      beat_fire_s;
    resp_t     resp_s;

    assign aw_in_s   = '{id: awid, addr: awaddr, len: awlen, size: awsize, burst: awburst};
    assign awready   = !rst && !aw_full_s;
    assign aw_push_s = awvalid && awready;

    axi_wr_slave_engine_sync_fifo #(
        .WIDTH ($bits(aw_entry_t)),
        .DEPTH (OUTSTANDING)
    ) u_aw_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (aw_push_s),
        .wdata (aw_in_s),
        .pop   (aw_pop_s),
        .rdata (aw_head_s),
        .full  (aw_full_s),
        .empty (aw_empty_s)
    );

    // W is a zero-latency passthrough to the sink while a burst is active.
    assign in_data_s   = (state_r == DATA);
    assign beat_fire_s = in_data_s && wvalid && mem_ready;
    assign wready      = !rst && in_data_s && mem_ready;
    assign mem_valid   = !rst && in_data_s && wvalid;
    assign mem_addr    = addr_r;
    assign mem_wdata   = wdata;
    assign mem_wstrb   = wstrb;

    // Next-state and queue handshake decode.
    always_comb begin
        state_nxt_s = state_r;
        aw_pop_s    = 1'b0;
        b_push_s    = 1'b0;
        case (state_r)
            IDLE: begin
                if (!aw_empty_s) begin
                    aw_pop_s    = 1'b1;
                    state_nxt_s = DATA;
                end else begin
                    state_nxt_s = IDLE;
                end
            end
            DATA: begin
                if (beat_fire_s && wlast) begin
                    state_nxt_s = RESP;
                end else begin
                    state_nxt_s = DATA;
                end
            end
            RESP: begin
                if (!b_full_s) begin
                    b_push_s    = 1'b1;
                    state_nxt_s = IDLE;
                end else begin
                    state_nxt_s = RESP;
                end
            end
            default: begin
                state_nxt_s = IDLE;
            end
        endcase
    end

    // State register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r <= IDLE;
        end else begin
            state_r <= state_nxt_s;
        end
    end

    // Burst context: loaded from the AW head, address/beat count advance per accepted beat.
    always_ff @(posedge clk) begin
        if (rst) begin
            id_r       <= '0;
            addr_r     <= '0;
            len_r      <= '0;
            size_r     <= '0;
            burst_r    <= 2'b00;
            beat_cnt_r <= '0;
        end else if (aw_pop_s) begin
            id_r       <= aw_head_s.id;
            addr_r     <= aw_head_s.addr;
            len_r      <= aw_head_s.len;
            size_r     <= aw_head_s.size;
            burst_r    <= aw_head_s.burst;
            beat_cnt_r <= '0;
        end else if (beat_fire_s) begin
            addr_r <= addr_r + (ADDR_W'(1) << size_r);
            if (beat_cnt_r != BEAT_MAX) begin
                beat_cnt_r <= beat_cnt_r + BEAT_ONE;
            end
        end
    end

`ifdef AXI_WR_ERR_CHK_EN
    logic beat_err_s;
    logic err_r;

    // A beat is erroneous on early/late wlast, ID mismatch or an unsupported burst shape.
    always_comb begin
        beat_err_s = 1'b0;
        if (beat_fire_s) begin
            beat_err_s = (wlast && (beat_cnt_r != {1'b0, len_r})) ||
                         (!wlast && (beat_cnt_r == {1'b0, len_r})) ||
                         (wid != id_r) ||
                         (burst_r != BURST_INCR) ||
                         (size_r > SIZE_W'($clog2(DATA_BYTES)));
        end else begin
            beat_err_s = 1'b0;
        end
    end

    // Sticky burst error, cleared when the next burst is loaded.
    always_ff @(posedge clk) begin
        if (rst) begin
            err_r <= 1'b0;
        end else if (aw_pop_s) begin
            err_r <= 1'b0;
        end else if (beat_err_s) begin
            err_r <= 1'b1;
        end
    end

    assign resp_s = err_r ? RESP_SLVERR : RESP_OKAY;
`else
    logic unused_s;

    assign resp_s   = RESP_OKAY;
    assign unused_s = ^{wid, len_r, burst_r, beat_cnt_r};
`endif

    assign b_in_s  = '{id: id_r, resp: resp_s};
    assign bvalid  = !rst && !b_empty_s;
    assign b_pop_s = bvalid && bready;
    assign bid     = b_head_s.id;
    assign bresp   = b_head_s.resp;

    axi_wr_slave_engine_sync_fifo #(
        .WIDTH ($bits(b_entry_t)),
        .DEPTH (B_DEPTH)
    ) u_b_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (b_push_s),
        .wdata (b_in_s),
        .pop   (b_pop_s),
        .rdata (b_head_s),
        .full  (b_full_s),
        .empty (b_empty_s)
    );

endmodule
